mult_result_combine: RTL and testbench
======================================

MULT_RESULT_COMBINE -- requirements
Module: mult_result_combine

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 36, signed partial-product width (18x18 multiply).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, packed result width.
REQ-003 SHALL have parameter ENABLE_64_BIT, default 1; when 0, sew 2'b11 is treated as 2'b10.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, partial-product beat valid.
REQ-007 SHALL have ports p0..p7, input, PROD_WIDTH each, signed partial products in the order defined in REQ-012 to REQ-015.
REQ-008 SHALL have port sew, input, 2, element width: 00=8, 01=16, 10=32, 11=64.
REQ-009 SHALL have port hi, input, 1, selects the high half of each product (vmulh); 0 selects the low half (vmul).
REQ-010 SHALL have port out_valid, output, 1, result valid, single-cycle pulse per result.
REQ-011 SHALL have port out_data, output, DATA_WIDTH, packed element results, element 0 in the LSBs.

Function
REQ-012 SEW8: p[k] SHALL be the product for element k (k=0..7); the lane output is bits [7:0] (hi=0) or [15:8] (hi=1).
REQ-013 SEW16: p[k] SHALL be the product for element k (k=0..3); p4..p7 are ignored; the lane output is [15:0] or [31:16].
REQ-014 SEW32: for element e (0..1), the products SHALL be ordered p[4e]=lo*lo, p[4e+1]=lo_a*hi_b, p[4e+2]=hi_a*lo_b, p[4e+3]=hi*hi; the full product is HH<<32 + (LH+HL)<<16 + LL, summed signed at least 66 bits wide; the lane output is [31:0] or [63:32].
REQ-015 SEW64: the element SHALL take two consecutive valid beats; in beat b, p[n] = a_(2b+(n>>2)) * b_(n&3), with weight 16*(i+j) over the 16-bit limbs i,j; accumulation is signed, at least 130 bits; out_data is product [63:0] or [127:64].
REQ-016 FSM states SHALL be IDLE and HALF: IDLE with a valid sew=11 beat goes to HALF and stores the weighted sum; HALF with a valid sew=11 beat adds, emits the result, and returns to IDLE.
REQ-017 In HALF, a valid beat with sew!=11 SHALL discard the partial accumulation, go to IDLE, and be processed normally for its own sew.
REQ-018 In HALF with in_valid=0, the state SHALL hold indefinitely.
REQ-019 Pipeline: the input register stage plus the combine/output register stage SHALL make out_valid assert exactly 2 cycles after the accepting beat (the second beat for SEW64).
REQ-020 Back-to-back valid beats SHALL be accepted every cycle with no bubbles; there is no backpressure.
REQ-021 out_data SHALL hold its last value while out_valid=0.
REQ-022 sew and hi SHALL be sampled with each beat; for SEW64, hi is taken from the second beat.

Reset
REQ-023 rst_n low SHALL immediately clear out_valid, out_data, the accumulator, and all pipeline registers to 0, and force the FSM to IDLE.
REQ-024 Beats in flight at reset SHALL be dropped; the first SEW64 beat after reset is treated as beat 0.

Structure
REQ-025 A shared package SHALL hold the SEW encodings, the PROD_WIDTH/DATA_WIDTH defaults, and the FSM state typedef.
REQ-026 One sub-module, mult_limb_sum (weighted shift-add of 8 products by SEW), SHALL be instantiated once.

Verification
REQ-027 SEW8, p0=-15, hi=0 -> out_data[7:0]=8'hF1; same beat with hi=1 -> 8'hFF; out_valid 2 cycles after in_valid.
REQ-028 SEW16, p0=36'h12340, hi=0 -> out_data[15:0]=16'h2340; hi=1 -> 16'h0001.
REQ-029 SEW32, p3=1, others 0: hi=0 -> out_data[31:0]=0; hi=1 -> out_data[31:0]=1.
REQ-030 SEW64, beat0 all 0, beat1 p2=1, hi=1 -> out_data=64'h1, exactly 1 out_valid pulse, 2 cycles after beat1.
REQ-031 SEW64 beat0, then a SEW8 beat with p0=7 -> no SEW64 result; a SEW8 result with byte0=8'h07 appears 2 cycles later.
REQ-032 rst_n pulsed low in HALF -> out_valid=0 and out_data=0 immediately; the next SEW64 pair gives a correct product.

Source files
------------

// File: rtl/mult_result_combine_pkg.sv
// Shared encodings, width defaults and FSM state type for the multiply result combiner.
package mult_result_combine_pkg;

  localparam int PROD_WIDTH_DEF = 36;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int ACC_WIDTH      = 130;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HALF = 1'b1
  } state_e;

  // Without 64-bit support a sew of 11 falls back to 32-bit elements.
  function automatic sew_e eff_sew(input logic [1:0] sew, input logic en64);
    if (!en64 && (sew == 2'b11)) begin
      return SEW_32;
    end else begin
      return sew_e'(sew);
    end
  endfunction

endpackage

// File: rtl/mult_limb_sum.sv
// Weighted shift-add of the eight partial products: two 32-bit elements, or one
// 64-bit beat whose limb weights depend on which beat of the pair it is.
module mult_limb_sum
  import mult_result_combine_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF
) (
  input  logic [7:0][PROD_WIDTH-1:0] prod_i,
  input  sew_e                       sew_i,
  input  logic                       beat_i,
  output logic signed [ACC_WIDTH-1:0] sum0_o,
  output logic signed [ACC_WIDTH-1:0] sum1_o
);

  logic signed [ACC_WIDTH-1:0] term_s;
  logic [7:0]                  shamt_s;

  // Sign-extend each product and shift it to its limb weight before summing.
  always_comb begin
    sum0_o  = '0;
    sum1_o  = '0;
    term_s  = '0;
    shamt_s = 8'd0;
    for (int n = 0; n < 8; n++) begin
      term_s = ACC_WIDTH'($signed(prod_i[n]));
      case (sew_i)
        SEW_64: begin
          shamt_s = 8'(16 * ((n / 4) + (n % 4)) + (beat_i ? 32 : 0));
          sum0_o  = sum0_o + (term_s <<< shamt_s);
        end
        SEW_32: begin
          case (n % 4)
            0:       shamt_s = 8'd0;
            3:       shamt_s = 8'd32;
            default: shamt_s = 8'd16;
          endcase
          if (n < 4) begin
            sum0_o = sum0_o + (term_s <<< shamt_s);
          end else begin
            sum1_o = sum1_o + (term_s <<< shamt_s);
          end
        end
        default: begin
          shamt_s = 8'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mult_result_combine.sv
// Combines signed partial products into packed vmul/vmulh results for SEW 8..64;
// 64-bit elements are accumulated over two consecutive valid beats.
module mult_result_combine
  import mult_result_combine_pkg::*;
#(
  parameter int PROD_WIDTH    = PROD_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter bit ENABLE_64_BIT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic signed [PROD_WIDTH-1:0] p0,
  input  logic signed [PROD_WIDTH-1:0] p1,
  input  logic signed [PROD_WIDTH-1:0] p2,
  input  logic signed [PROD_WIDTH-1:0] p3,
  input  logic signed [PROD_WIDTH-1:0] p4,
  input  logic signed [PROD_WIDTH-1:0] p5,
  input  logic signed [PROD_WIDTH-1:0] p6,
  input  logic signed [PROD_WIDTH-1:0] p7,
  input  logic [1:0]                   sew,
  input  logic                         hi,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data
);

  logic                        in_valid_q, in_valid_d;
  logic [7:0][PROD_WIDTH-1:0]  prod_q, prod_d;
  sew_e                        sew_q, sew_d;
  logic                        hi_q, hi_d;

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;

  logic signed [ACC_WIDTH-1:0] sum0_s, sum1_s, full_s;
  logic                        unused_bits_s;

  // Input stage captures a beat only when it is valid.
  always_comb begin
    in_valid_d = in_valid;
    if (in_valid) begin
      prod_d = {p7, p6, p5, p4, p3, p2, p1, p0};
      sew_d  = eff_sew(sew, ENABLE_64_BIT);
      hi_d   = hi;
    end else begin
      prod_d = prod_q;
      sew_d  = sew_q;
      hi_d   = hi_q;
    end
  end

  // Input stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      prod_q     <= '0;
      sew_q      <= SEW_8;
      hi_q       <= 1'b0;
    end else begin
      in_valid_q <= in_valid_d;
      prod_q     <= prod_d;
      sew_q      <= sew_d;
      hi_q       <= hi_d;
    end
  end

  mult_limb_sum #(.PROD_WIDTH(PROD_WIDTH)) u_limb_sum (
    .prod_i (prod_q),
    .sew_i  (sew_q),
    .beat_i (state_q == ST_HALF),
    .sum0_o (sum0_s),
    .sum1_o (sum1_s)
  );

  assign unused_bits_s = ^{sum1_s[ACC_WIDTH-1:64], full_s[ACC_WIDTH-1:128]};

  // Lane selection and the two-beat SEW64 sequencing; any non-64 beat drops a pending half.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    full_s      = acc_q + sum0_s;
    if (in_valid_q) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      case (sew_q)
        SEW_8: begin
          out_valid_d = 1'b1;
          for (int k = 0; k < 8; k++) begin
            out_data_d[8*k +: 8] = hi_q ? prod_q[k][15:8] : prod_q[k][7:0];
          end
        end
        SEW_16: begin
          out_valid_d = 1'b1;
          for (int k = 0; k < 4; k++) begin
            out_data_d[16*k +: 16] = hi_q ? prod_q[k][31:16] : prod_q[k][15:0];
          end
        end
        SEW_32: begin
          out_valid_d = 1'b1;
          out_data_d  = hi_q ? DATA_WIDTH'({sum1_s[63:32], sum0_s[63:32]})
                             : DATA_WIDTH'({sum1_s[31:0], sum0_s[31:0]});
        end
        SEW_64: begin
          if (state_q == ST_IDLE) begin
            state_d = ST_HALF;
            acc_d   = sum0_s;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = hi_q ? DATA_WIDTH'(full_s[127:64]) : DATA_WIDTH'(full_s[63:0]);
          end
        end
        default: begin
          out_valid_d = 1'b0;
        end
      endcase
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Combine/output stage registers including the FSM state and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mult_result_combine.sv
// Random-stimulus bench: operands are drawn, split into partial products, and the
// expected lanes come from the full signed product of those operands.
module tb_mult_result_combine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  sew;
  logic        hi;
  logic [35:0] p  [8];
  logic [35:0] np [8];
  logic        out_valid;
  logic [63:0] out_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        s1v, s2v;
  logic [63:0] s1d, s2d, held;
  logic        m_half;
  logic signed [63:0] m_a, m_b;
  string       tag;

  always #5 clk = ~clk;

  mult_result_combine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .p0(p[0]), .p1(p[1]), .p2(p[2]), .p3(p[3]),
    .p4(p[4]), .p5(p[5]), .p6(p[6]), .p7(p[7]),
    .sew(sew), .hi(hi), .out_valid(out_valid), .out_data(out_data)
  );

  function automatic logic [63:0] rnd(input int w);
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 64'd1 << (w - 1);
    else if (sel == 1) return '1;
    else return {$urandom(), $urandom()};
  endfunction

  function automatic logic signed [16:0] limb(input logic [63:0] x, input int i, input bit top);
    logic [15:0] l;
    l = x[16*i +: 16];
    return top ? {l[15], l} : {1'b0, l};
  endfunction

  function automatic logic [35:0] pp(input logic signed [16:0] a, input logic signed [16:0] b);
    logic signed [35:0] r;
    r = a * b;
    return r;
  endfunction

  task automatic check_now(input logic ev, input logic [63:0] ed);
    n_cmp++;
    if (out_valid !== ev) begin
      n_bad++;
      $display("FAIL %s out_valid: got %0b want %0b", tag, out_valid, ev);
    end
    n_cmp++;
    if (out_data !== ed) begin
      n_bad++;
      $display("FAIL %s out_data: got %h want %h", tag, out_data, ed);
    end
  endtask

  // One cycle: check outputs due now, advance the 2-deep expectation pipe, drive a beat.
  task automatic step(input logic v, input logic [1:0] s, input logic h,
                      input logic ev, input logic [63:0] ed);
    @(negedge clk);
    check_now(s2v, s2v ? s2d : held);
    if (s2v) held = s2d;
    s2v = s1v; s2d = s1d;
    s1v = ev;  s1d = ed;
    in_valid = v; sew = s; hi = h;
    for (int i = 0; i < 8; i++) p[i] = np[i];
  endtask

  task automatic clear_np();
    for (int i = 0; i < 8; i++) np[i] = 36'd0;
  endtask

  task automatic model_beat(input logic v, input logic [1:0] s, input logic h);
    logic ev;
    logic [63:0] ed;
    logic signed [7:0]   a8, b8;
    logic signed [15:0]  a16, b16, r16;
    logic signed [31:0]  a32, b32, r32;
    logic signed [63:0]  r64;
    logic signed [127:0] r128;
    int beat;
    ev = 1'b0;
    ed = 64'd0;
    beat = 0;
    for (int i = 0; i < 8; i++) np[i] = 36'({$urandom(), $urandom()});
    if (v) begin
      ev = 1'b1;
      case (s)
        2'b00: begin
          m_half = 1'b0;
          for (int k = 0; k < 8; k++) begin
            a8 = 8'(rnd(8)); b8 = 8'(rnd(8));
            r16 = a8 * b8;
            np[k] = {{20{r16[15]}}, r16};
            ed[8*k +: 8] = h ? r16[15:8] : r16[7:0];
          end
        end
        2'b01: begin
          m_half = 1'b0;
          for (int k = 0; k < 4; k++) begin
            a16 = 16'(rnd(16)); b16 = 16'(rnd(16));
            r32 = a16 * b16;
            np[k] = {{4{r32[31]}}, r32};
            ed[16*k +: 16] = h ? r32[31:16] : r32[15:0];
          end
        end
        2'b10: begin
          m_half = 1'b0;
          for (int e = 0; e < 2; e++) begin
            a32 = 32'(rnd(32)); b32 = 32'(rnd(32));
            r64 = a32 * b32;
            np[4*e]   = pp(limb(64'(a32), 0, 1'b0), limb(64'(b32), 0, 1'b0));
            np[4*e+1] = pp(limb(64'(a32), 0, 1'b0), limb(64'(b32), 1, 1'b1));
            np[4*e+2] = pp(limb(64'(a32), 1, 1'b1), limb(64'(b32), 0, 1'b0));
            np[4*e+3] = pp(limb(64'(a32), 1, 1'b1), limb(64'(b32), 1, 1'b1));
            ed[32*e +: 32] = h ? r64[63:32] : r64[31:0];
          end
        end
        default: begin
          if (!m_half) begin
            m_a = rnd(64); m_b = rnd(64);
            beat = 0; ev = 1'b0; m_half = 1'b1;
          end else begin
            beat = 1; m_half = 1'b0;
            r128 = m_a * m_b;
            ed = h ? r128[127:64] : r128[63:0];
          end
          for (int n = 0; n < 8; n++)
            np[n] = pp(limb(m_a, 2*beat + n/4, (2*beat + n/4) == 3),
                       limb(m_b, n%4, (n%4) == 3));
        end
      endcase
    end
    step(v, s, h, ev, ed);
  endtask

  initial begin
    int r;
    logic [1:0] rs;
    rst_n = 1'b0; in_valid = 1'b0; sew = 2'b00; hi = 1'b0;
    for (int i = 0; i < 8; i++) begin p[i] = 36'd0; np[i] = 36'd0; end
    s1v = 1'b0; s2v = 1'b0; s1d = 64'd0; s2d = 64'd0; held = 64'd0; m_half = 1'b0;
    tag = "reset";
    #2 check_now(1'b0, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    tag = "sew8";
    clear_np(); np[0] = -36'sd15;
    step(1'b1, 2'b00, 1'b0, 1'b1, 64'hF1);
    step(1'b1, 2'b00, 1'b1, 1'b1, 64'hFF);
    step(1'b0, 2'b00, 1'b0, 1'b0, 64'd0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 64'd0);

    tag = "sew16";
    clear_np(); np[0] = 36'h12340;
    step(1'b1, 2'b01, 1'b0, 1'b1, 64'h2340);
    step(1'b1, 2'b01, 1'b1, 1'b1, 64'h0001);

    tag = "sew32";
    clear_np(); np[3] = 36'd1;
    step(1'b1, 2'b10, 1'b0, 1'b1, 64'h0);
    step(1'b1, 2'b10, 1'b1, 1'b1, 64'h1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 64'd0);

    tag = "sew64";
    clear_np();
    step(1'b1, 2'b11, 1'b0, 1'b0, 64'd0);
    np[2] = 36'd1;
    step(1'b1, 2'b11, 1'b1, 1'b1, 64'h1);
    repeat (3) step(1'b0, 2'b00, 1'b0, 1'b0, 64'd0);

    tag = "abort64";
    clear_np(); np[0] = 36'd5;
    step(1'b1, 2'b11, 1'b0, 1'b0, 64'd0);
    clear_np(); np[0] = 36'd7;
    step(1'b1, 2'b00, 1'b0, 1'b1, 64'h07);
    clear_np();
    step(1'b1, 2'b11, 1'b0, 1'b0, 64'd0);
    np[2] = 36'd1;
    step(1'b1, 2'b11, 1'b1, 1'b1, 64'h1);
    repeat (2) step(1'b0, 2'b00, 1'b0, 1'b0, 64'd0);

    tag = "rst_half";
    clear_np(); np[0] = 36'd9;
    step(1'b1, 2'b11, 1'b0, 1'b0, 64'd0);
    repeat (2) step(1'b0, 2'b00, 1'b0, 1'b0, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_now(1'b0, 64'd0);
    s1v = 1'b0; s2v = 1'b0; held = 64'd0; m_half = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    tag = "post_rst";
    model_beat(1'b1, 2'b11, 1'b0);
    model_beat(1'b1, 2'b11, 1'b1);
    model_beat(1'b0, 2'b00, 1'b0);
    model_beat(1'b0, 2'b00, 1'b0);

    tag = "random";
    repeat (3000) begin
      r = $urandom_range(0, 9);
      rs = (r < 4) ? 2'b11 : (r < 6) ? 2'b10 : (r < 8) ? 2'b01 : 2'b00;
      model_beat($urandom_range(0, 3) != 0, rs, 1'($urandom_range(0, 1)));
    end
    repeat (3) model_beat(1'b0, 2'b00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
